mem_port_arbiter: RTL and testbench

- Shares the single-ported data memory between instruction fetch (IF) and load/store (LS), so the core can run multi-cycle with one memory.
- Sits between the fetch unit, the load/store path (MemRead/MemWrite from Controller) and the memory macro.
- Runs one access at a time through a fixed-latency FSM.
- LS has priority; a starvation guard guarantees IF progress.

---
 rtl/riscv_arb_pkg.sv | 16 +
 rtl/mem_lat_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory read-latency counter: load to 1 on the access cycle, count up while
// waiting, flag when the memory's read data is due.
module mem_lat_counter #(
  parameter int MEM_LAT = 2,
  parameter int CW      = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= CW'(1);
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(MEM_LAT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store; one access
// at a time, LS priority with a starvation guard. ARB_PERF_CNT_EN adds stall counters.
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   if_stall_cnt,
  output logic [31:0]   ls_stall_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state;
  owner_t        owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, ls_rdata_q;
  logic [SW-1:0] starve_cnt;
  logic          idle, force_if, ls_win, lat_tc;

  assign idle     = (state == IDLE);
  assign force_if = if_req && (starve_cnt == SW'(STARVE_MAX));
  assign ls_win   = ls_req && !force_if;
  assign ls_gnt   = idle && ls_win;
  assign if_gnt   = idle && if_req && !ls_win;

  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (state == ACCESS),
    .inc    ((state == WAIT) && !lat_tc),
    .tc     (lat_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_gnt) begin
            owner   <= OWN_LS;
            we_q    <= ls_we;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            // Only LS wins that leave IF waiting count toward forcing IF.
            if (!if_req)                                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))     starve_cnt <= starve_cnt + 1'b1;
            state   <= ACCESS;
          end else if (if_gnt) begin
            owner      <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= if_addr;
            wdata_q    <= '0;
            starve_cnt <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: state <= WAIT;
        WAIT: if (lat_tc) begin
          if (owner == OWN_IF) if_rdata_q <= mem_rdata;
          else                 ls_rdata_q <= we_q ? '0 : mem_rdata;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign ls_rvalid = (state == RESP) && (owner == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = !idle;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_stall_cnt <= '0;
      ls_stall_cnt <= '0;
    end else begin
      if (if_req && !if_gnt && (if_stall_cnt != '1)) if_stall_cnt <= if_stall_cnt + 1'b1;
      if (ls_req && !ls_gnt && (ls_stall_cnt != '1)) ls_stall_cnt <= ls_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model plus a behavioural
// memory with garbage on mem_rdata outside the valid read cycle.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, ls_stall_cnt;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt(if_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  // Memory macro: data appears exactly LAT cycles after the mem_en cycle.
  logic [31:0] mem [16];
  logic [31:0] rdq [LAT];
  logic        rv  [LAT];
  logic [31:0] garbage;
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    else if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    rv[0]  <= mem_en && !mem_we;
    rdq[0] <= mem[mem_addr[5:2]];
    for (int i = 1; i < LAT; i++) begin
      rv[i]  <= rv[i-1];
      rdq[i] <= rdq[i-1];
    end
    garbage <= $urandom;
  end
  assign mem_rdata = rv[LAT-1] ? rdq[LAT-1] : garbage;

  int checks = 0, failures = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: age = cycles since grant (-1 when idle).
  int          age, starve, ngr;
  logic        m_ls, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata, m_ifst, m_lsst;
  logic [31:0] mdl_mem [16];
  logic [7:0]  order;
  logic        s_if_gnt, s_ls_gnt, s_if_rv, s_ls_rv, s_busy, s_en, s_we;
  logic [31:0] s_addr, s_wdata, s_if_rdata, s_ls_rdata;

  task automatic model_reset();
    age = -1; starve = 0; m_ifst = 0; m_lsst = 0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_word(i);
  endtask

  task automatic step(input logic ir, input logic [31:0] ia, input logic lr,
                      input logic lw, input logic [31:0] la, input logic [31:0] ld);
    logic e_ifg, e_lsg, e_en, e_ifv, e_lsv;
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    @(negedge clk);
    e_ifg = 0; e_lsg = 0;
    if (age < 0) begin
      if (lr && !(ir && starve == SMAX)) e_lsg = 1;
      else if (ir)                       e_ifg = 1;
    end
    e_en  = (age == 1);
    e_ifv = (age == LAT + 2) && !m_ls;
    e_lsv = (age == LAT + 2) && m_ls;
    chk("if_gnt", if_gnt, e_ifg);
    chk("ls_gnt", ls_gnt, e_lsg);
    chk("busy", busy, age >= 0);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_en && m_we);
    if (e_en) chk("mem_addr", mem_addr, m_addr);
    if (e_en && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rvalid", if_rvalid, e_ifv);
    chk("ls_rvalid", ls_rvalid, e_lsv);
    if (e_ifv) chk("if_rdata", if_rdata, m_rdata);
    if (e_lsv) chk("ls_rdata", ls_rdata, m_rdata);
    if (ir && !e_ifg && m_ifst != '1) m_ifst++;
    if (lr && !e_lsg && m_lsst != '1) m_lsst++;
`ifdef ARB_PERF_CNT_EN
    chk("if_stall_cnt", if_stall_cnt, m_ifst);
    chk("ls_stall_cnt", ls_stall_cnt, m_lsst);
`endif
    s_if_gnt = if_gnt; s_ls_gnt = ls_gnt; s_if_rv = if_rvalid; s_ls_rv = ls_rvalid;
    s_busy = busy; s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    s_if_rdata = if_rdata; s_ls_rdata = ls_rdata;
    if (age == 1) begin
      if (m_we) begin mdl_mem[m_addr[5:2]] = m_wdata; m_rdata = 0; end
      else m_rdata = mdl_mem[m_addr[5:2]];
    end
    if (age == LAT + 2) age = -1;
    else if (age >= 0)  age++;
    if (e_lsg) begin
      age = 1; m_ls = 1; m_we = lw; m_addr = la; m_wdata = ld;
      starve = ir ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
      order = {order[6:0], 1'b0}; ngr++;
    end else if (e_ifg) begin
      age = 1; m_ls = 0; m_we = 0; m_addr = ia; m_wdata = 0; starve = 0;
      order = {order[6:0], 1'b1}; ngr++;
    end
  endtask

  task automatic idle_steps(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(string n);
    chk({n, "_gnt"}, {if_gnt, ls_gnt}, 0);
    chk({n, "_rvalid"}, {if_rvalid, ls_rvalid}, 0);
    chk({n, "_mem"}, {mem_en, mem_we, busy}, 0);
    chk({n, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    logic ir, lr, lw;
    logic [31:0] ia, la, ld;
    model_reset();
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_rdata", if_rdata | ls_rdata, 0);
    @(negedge clk); rst_n = 1;

    // IF only: rvalid at G+4 with memory word 4
    step(1, 32'h10, 0, 0, 0, 0);   chk("t1_gnt_G", s_if_gnt, 1);
    step(0, 0, 0, 0, 0, 0);        chk("t1_en_G1", s_en, 1);
    idle_steps(2);
    step(0, 0, 0, 0, 0, 0);        chk("t1_rv_G4", s_if_rv, 1);
    chk("t1_data", s_if_rdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);        chk("t1_busy_G5", s_busy, 0);

    // LS store to 0x20
    step(0, 0, 1, 1, 32'h20, 32'h1234); chk("t2_gnt", s_ls_gnt, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_en_we", {s_en, s_we}, 2'b11);
    chk("t2_addr", s_addr, 32'h20);
    chk("t2_wdata", s_wdata, 32'h1234);
    idle_steps(2);
    step(0, 0, 0, 0, 0, 0);        chk("t2_rv", s_ls_rv, 1);
    chk("t2_rdata", s_ls_rdata, 0);
    idle_steps(1);

    // Simultaneous: LS load of 0x20 first, IF granted the cycle after ls_rvalid
    step(1, 32'h30, 1, 0, 32'h20, 0);
    chk("t3_first", {s_ls_gnt, s_if_gnt}, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      step(1, 32'h30, 0, 0, 0, 0);
      chk("t3_if_wait", s_if_gnt, 0);
    end
    chk("t3_ls_rv", s_ls_rv, 1);
    chk("t3_ls_data", s_ls_rdata, 32'h1234);
    step(1, 32'h30, 0, 0, 0, 0);   chk("t3_if_gnt", s_if_gnt, 1);
    idle_steps(5);

    // Starvation: both held high
    order = 0; ngr = 0;
    for (int k = 0; k < 60 && ngr < 5; k++) step(1, 32'h4, 1, 0, 32'h8, 0);
    chk("t4_grants", ngr, 5);
    chk("t4_order", order[4:0], 5'b00010);
    idle_steps(6);

    // Reset mid-WAIT, then a fresh IF fetch
    step(1, 32'h10, 0, 0, 0, 0);   chk("t5_gnt", s_if_gnt, 1);
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 0;
    #1 chk_all_zero("t5_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all_zero("t5_hold");
    end
    rst_n = 1;
    model_reset();
    step(1, 32'h10, 0, 0, 0, 0);   chk("t5_regnt", s_if_gnt, 1);
    idle_steps(3);
    step(0, 0, 0, 0, 0, 0);        chk("t5_rv", s_if_rv, 1);
    chk("t5_data", s_if_rdata, 32'hDEADBEEF);
    idle_steps(1);

    // Random traffic, requests held until granted
    ir = 0; lr = 0; lw = 0; ia = 0; la = 0; ld = 0;
    for (int k = 0; k < 600; k++) begin
      step(ir, ia, lr, lw, la, ld);
      if (s_if_gnt || !ir) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (s_ls_gnt || !lr) begin
        lr = ($urandom_range(0, 2) != 0);
        lw = $urandom_range(0, 1) == 1;
        la = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        ld = $urandom;
      end
    end
    idle_steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
